id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage. Sits between fetch and the register-read/execute stage.
- Decodes the class ISA fields into control and operand signals, extends the immediate, and tracks in-flight register writes in a scoreboard to stall RAW/WAW hazards.
- Handles pipeline flush and a sticky HALT state.
- Successor to the flat combinational decoder: parametrised width, register count and scoreboard depth, with handshake and hazard behaviour the combinational decoder lacks.

Parameters:
DATA_W, 32, width of extended immediate output
ADDR_W, 16, width of PC carried with instruction
NUM_REGS, 8, architectural registers (2..8); field index >= NUM_REGS is illegal
PEND_W, 2, width of per-register pending-write counter (max in-flight writes = 2^PEND_W-1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents instruction
in_instr  in  32  instruction word
in_pc  in  ADDR_W  PC of instruction
in_ready  out  1  stage accepts this cycle
out_valid  out  1  decoded instruction valid
out_ready  in  1  downstream accepts
out_pc  out  ADDR_W  registered PC
out_class  out  2  instr[31:30]
out_alu_oc  out  3  instr[27:25]
out_special  out  1  instr[29] for classes 00/01, else 0
out_set_flags  out  1  instr[29]&instr[28] for classes 00/01, else 0
out_cond  out  4  instr[24:21] for conditional branch, else 0
out_dest, out_src1, out_src2  out  3 each  dest [24:22], src1 [21:19], src2 [18:16]; 0 when unused
out_rd1_en, out_rd2_en, out_wr_en  out  1 each  src1 read, src2 read, dest write
out_imm  out  DATA_W  extended instr[15:0]
out_mem_rd, out_mem_wr, out_branch, out_illegal, out_halt  out  1 each  decoded kind flags
halted  out  1  HALT has issued
wb_valid  in  1  writeback retires one register write
wb_addr  in  3  register retired
flush  in  1  kill stage contents

Behaviour:
- Decode table (rd1/rd2/wr; src1 field = [21:19], src2 field = [18:16]):
  - Class 00 MOV: wr dest.
  - Class 00 MOVT: rd1 = dest field, wr dest.
  - Class 00 ADD..XORS / LSL / LSR / CLR / SET: rd1, wr.
  - Class 01 two-op ALU (the ten add..xors codes): rd1, rd2, wr.
  - Class 01 NOT (10110): rd1, wr.
  - Class 10, instr[25]=1 load: rd1 pointer, wr dest, mem_rd.
  - Class 10, instr[25]=0 store: rd1 pointer, rd2 = dest field (data), mem_wr.
  - Class 11 [28:25]=0000 B; 0001 B.cond (cond valid); 0010 BR (rd1 pointer). All three set branch.
  - Class 11 [28]=1: HALT (priority). Otherwise [27]=1: NOP.
  - Any other encoding, or any used field >= NUM_REGS: illegal=1, all enables 0.
- Immediate: sign-extended for class 10 and class 11 branches; zero-extended otherwise. MOVT passes imm unshifted.
- Latency: 1 cycle, in_valid&in_ready to out_valid.
- Output register advances when !out_valid | out_ready. Outputs are held stable while out_valid & !out_ready.
- Hazard: stall if any enabled source, or the enabled dest, has pending count != 0. Also stall if the dest counter is at its maximum.
- in_ready = advance & !hazard & !halted & !flush.
- Scoreboard:
  - On accept with wr_en, pending[dest] += 1.
  - On wb_valid, pending[wb_addr] -= 1; decrement at 0 is ignored.
  - Increment and decrement to the same register in the same cycle: unchanged.
- flush: out_valid <= 0 next cycle and no accept that cycle. Scoreboard is untouched, because issued writes still retire via wb. halted is untouched.
- States:
  - RUN -> HALTED when a HALT is accepted. HALT still propagates to out_valid once.
  - HALTED: in_ready=0, halted=1. Exits only via rst.
- Reset (rst mid-operation included): out_valid=0, all out_* fields 0, halted=0, all pending=0. in_ready is 1 the cycle after reset.

Test Plan:
- ADD r1,r2,r3 (0x62 encoding 01_10001_001_010_011) with out_ready=1 -> next cycle out_valid=1, dest=1, src1=2, src2=3, rd1/rd2/wr=1, special=1, set_flags=0.
- MOV r1,#0x8001 then ADD r2,r1,r1 with no wb -> in_ready=0 on ADD. Assert wb_valid with wb_addr=1 -> ADD accepted next cycle. pending[1]=0 then 1→0, pending[2]=1.
- LD with imm 0xFFFC -> out_imm=0xFFFFFFFC, mem_rd=1. OR with imm 0xFFFC -> out_imm=0x0000FFFC.
- out_ready=0 for 3 cycles with a valid output -> outputs unchanged and in_ready=0. Release -> the next instruction appears 1 cycle later.
- Accept MOV r4 then flush -> out_valid=0 next cycle, pending[4] stays 1. WB r4 -> 0.
- HALT -> out_halt=1 one cycle, halted=1, in_ready=0 forever. rst -> halted=0, in_ready=1.

Source files
------------

// File: rtl/id_stage_if.sv
// Handshake and result bundle between fetch, the decode stage, and writeback/control.
// The stage itself plugs in through the slave modport; its environment uses master.
interface id_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic [31:0]       in_instr;
    logic [ADDR_W-1:0] in_pc;
    logic              in_ready;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [1:0]        out_class;
    logic [2:0]        out_alu_oc;
    logic              out_special;
    logic              out_set_flags;
    logic [3:0]        out_cond;
    logic [2:0]        out_dest;
    logic [2:0]        out_src1;
    logic [2:0]        out_src2;
    logic              out_rd1_en;
    logic              out_rd2_en;
    logic              out_wr_en;
    logic [DATA_W-1:0] out_imm;
    logic              out_mem_rd;
    logic              out_mem_wr;
    logic              out_branch;
    logic              out_illegal;
    logic              out_halt;

    logic              halted;
    logic              wb_valid;
    logic [2:0]        wb_addr;
    logic              flush;

    modport master (
        output in_valid, in_instr, in_pc, out_ready, wb_valid, wb_addr, flush,
        input  in_ready, out_valid, out_pc, out_class, out_alu_oc, out_special,
               out_set_flags, out_cond, out_dest, out_src1, out_src2, out_rd1_en,
               out_rd2_en, out_wr_en, out_imm, out_mem_rd, out_mem_wr, out_branch,
               out_illegal, out_halt, halted
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, wb_valid, wb_addr, flush,
        output in_ready, out_valid, out_pc, out_class, out_alu_oc, out_special,
               out_set_flags, out_cond, out_dest, out_src1, out_src2, out_rd1_en,
               out_rd2_en, out_wr_en, out_imm, out_mem_rd, out_mem_wr, out_branch,
               out_illegal, out_halt, halted
    );
endinterface

// File: rtl/id_stage.sv
// Registered decode stage: decodes one instruction per handshake, stalls on RAW/WAW
// hazards via a pending-write scoreboard, and supports flush and a sticky HALT.
module id_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int PEND_W   = 2
) (
    input logic       clk,
    input logic       rst,
    id_stage_if.slave bus
);
    localparam int                MAX_REGS = 8;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    // Class 00/01 opcodes in [29:25]; the ALU group is 1S_ooo with ooo = and/add/sub/or/xor.
    localparam logic [4:0] OP_MOV  = 5'b00000;
    localparam logic [4:0] OP_MOVT = 5'b00001;
    localparam logic [4:0] OP_NOT  = 5'b10110;

    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic [1:0] cls;
        logic [2:0] alu_oc;
        logic       special;
        logic       set_flags;
        logic [3:0] cond;
        logic [2:0] dest;
        logic [2:0] src1;
        logic [2:0] src2;
        logic       rd1_en;
        logic       rd2_en;
        logic       wr_en;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       illegal;
        logic       halt;
    } dec_t;

    function automatic logic reg_ok(input logic [2:0] r);
        return 32'(r) < 32'(NUM_REGS);
    endfunction

    logic [31:0]       instr;
    logic [1:0]        cls;
    logic [4:0]        op;
    logic [2:0]        f_d;
    logic [2:0]        f_1;
    logic [2:0]        f_2;
    logic              alu_op;
    logic              shift_op;
    logic              branch_enc;
    logic              sext;
    dec_t              dcd;
    logic [DATA_W-1:0] imm;

    logic              hazard;
    logic              advance;
    logic              in_ready;
    logic              accept;
    logic              halted;
    state_t            state;
    state_t            state_next;

    logic              out_valid;
    dec_t              q;
    logic [ADDR_W-1:0] q_pc;
    logic [DATA_W-1:0] q_imm;

    logic [PEND_W-1:0] pending [MAX_REGS];
    logic [MAX_REGS-1:0] sb_inc;
    logic [MAX_REGS-1:0] sb_dec;

    assign instr      = bus.in_instr;
    assign cls        = instr[31:30];
    assign op         = instr[29:25];
    assign f_d        = instr[24:22];
    assign f_1        = instr[21:19];
    assign f_2        = instr[18:16];
    assign alu_op     = op[4] && (op[2:0] <= 3'd4);
    assign shift_op   = (op >= 5'b00010) && (op <= 5'b00101);
    assign branch_enc = (cls == 2'b11) && !instr[28] && (instr[27:25] <= 3'b010);
    assign sext       = (cls == 2'b10) || branch_enc;
    assign imm        = sext ? {{(DATA_W-16){instr[15]}}, instr[15:0]}
                             : {{(DATA_W-16){1'b0}}, instr[15:0]};

    always_comb begin
        // NOTE: dcd is fully defaulted first, so no decode path can infer a latch.
        dcd        = '0;
        dcd.cls    = cls;
        dcd.alu_oc = instr[27:25];
        if (!cls[1]) begin
            dcd.special   = instr[29];
            dcd.set_flags = instr[29] & instr[28];
        end
        case (cls)
            2'b00: begin
                if (op == OP_MOV) begin
                    dcd.wr_en = 1'b1;
                    dcd.dest  = f_d;
                end else if (op == OP_MOVT) begin
                    dcd.rd1_en = 1'b1;
                    dcd.src1   = f_d;
                    dcd.wr_en  = 1'b1;
                    dcd.dest   = f_d;
                end else if (alu_op || shift_op) begin
                    dcd.rd1_en = 1'b1;
                    dcd.src1   = f_1;
                    dcd.wr_en  = 1'b1;
                    dcd.dest   = f_d;
                end else begin
                    dcd.illegal = 1'b1;
                end
            end
            2'b01: begin
                if (alu_op) begin
                    dcd.rd1_en = 1'b1;
                    dcd.src1   = f_1;
                    dcd.rd2_en = 1'b1;
                    dcd.src2   = f_2;
                    dcd.wr_en  = 1'b1;
                    dcd.dest   = f_d;
                end else if (op == OP_NOT) begin
                    dcd.rd1_en = 1'b1;
                    dcd.src1   = f_1;
                    dcd.wr_en  = 1'b1;
                    dcd.dest   = f_d;
                end else begin
                    dcd.illegal = 1'b1;
                end
            end
            2'b10: begin
                dcd.rd1_en = 1'b1;
                dcd.src1   = f_1;
                if (instr[25]) begin
                    dcd.wr_en  = 1'b1;
                    dcd.dest   = f_d;
                    dcd.mem_rd = 1'b1;
                end else begin
                    // Store data comes from the dest field through the second read port.
                    dcd.rd2_en = 1'b1;
                    dcd.src2   = f_d;
                    dcd.mem_wr = 1'b1;
                end
            end
            default: begin
                if (instr[28]) begin
                    dcd.halt = 1'b1;
                end else if (branch_enc) begin
                    dcd.branch = 1'b1;
                    if (instr[27:25] == 3'b001) dcd.cond = instr[24:21];
                    if (instr[27:25] == 3'b010) begin
                        dcd.rd1_en = 1'b1;
                        dcd.src1   = f_1;
                    end
                end else if (!instr[27]) begin
                    dcd.illegal = 1'b1;
                end
            end
        endcase

        if ((dcd.rd1_en && !reg_ok(dcd.src1)) || (dcd.rd2_en && !reg_ok(dcd.src2)) ||
            (dcd.wr_en && !reg_ok(dcd.dest)))
            dcd.illegal = 1'b1;

        if (dcd.illegal) begin
            dcd.cond   = '0;
            dcd.dest   = '0;
            dcd.src1   = '0;
            dcd.src2   = '0;
            dcd.rd1_en = 1'b0;
            dcd.rd2_en = 1'b0;
            dcd.wr_en  = 1'b0;
            dcd.mem_rd = 1'b0;
            dcd.mem_wr = 1'b0;
            dcd.branch = 1'b0;
            dcd.halt   = 1'b0;
        end
    end

    assign hazard = (dcd.rd1_en && (pending[dcd.src1] != '0)) ||
                    (dcd.rd2_en && (pending[dcd.src2] != '0)) ||
                    (dcd.wr_en && ((pending[dcd.dest] != '0) || (pending[dcd.dest] == PEND_MAX)));

    assign advance  = !out_valid || bus.out_ready;
    assign in_ready = advance && !hazard && !halted && !bus.flush;
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:    if (accept && dcd.halt) state_next = HALTED;
            HALTED: state_next = HALTED;
        endcase
    end

    always_comb begin
        halted = (state == HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
            q_pc      <= '0;
            q_imm     <= '0;
        end else begin
            if (bus.flush)    out_valid <= 1'b0;
            else if (advance) out_valid <= accept;
            if (accept) begin
                q     <= dcd;
                q_pc  <= bus.in_pc;
                q_imm <= imm;
            end
        end
    end

    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        if (accept && dcd.wr_en) sb_inc[dcd.dest] = 1'b1;
        if (bus.wb_valid && reg_ok(bus.wb_addr)) sb_dec[bus.wb_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: the scoreboard is reset entry by entry; a stale count would stall forever.
        if (rst) begin
            for (int i = 0; i < MAX_REGS; i++) pending[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_REGS; i++) begin
                if (sb_inc[i] && !sb_dec[i])
                    pending[i] <= pending[i] + PEND_W'(1);
                else if (!sb_inc[i] && sb_dec[i] && (pending[i] != '0))
                    pending[i] <= pending[i] - PEND_W'(1);
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_pc        = q_pc;
    assign bus.out_class     = q.cls;
    assign bus.out_alu_oc    = q.alu_oc;
    assign bus.out_special   = q.special;
    assign bus.out_set_flags = q.set_flags;
    assign bus.out_cond      = q.cond;
    assign bus.out_dest      = q.dest;
    assign bus.out_src1      = q.src1;
    assign bus.out_src2      = q.src2;
    assign bus.out_rd1_en    = q.rd1_en;
    assign bus.out_rd2_en    = q.rd2_en;
    assign bus.out_wr_en     = q.wr_en;
    assign bus.out_imm       = q_imm;
    assign bus.out_mem_rd    = q.mem_rd;
    assign bus.out_mem_wr    = q.mem_wr;
    assign bus.out_branch    = q.branch;
    assign bus.out_illegal   = q.illegal;
    assign bus.out_halt      = q.halt;
    assign bus.halted        = halted;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode fields, hazards, stall, flush, HALT and reset,
// with hand-computed expected values.
module tb_id_stage;
    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    id_stage_if #(.DATA_W(32), .ADDR_W(16)) bus ();

    id_stage #(.DATA_W(32), .ADDR_W(16), .NUM_REGS(8), .PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_pc     = 16'h0;
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = 3'd0;
        bus.flush     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset halted",    32'(bus.halted),    32'd0);
        check("reset out_imm",   bus.out_imm,        32'd0);
        check("reset in_ready",  32'(bus.in_ready),  32'd1);

        // ADD r1,r2,r3
        bus.in_valid = 1'b1; bus.in_instr = 32'h6253_0000; bus.in_pc = 16'h0010;
        tick();
        bus.in_valid = 1'b0;
        check("add out_valid",  32'(bus.out_valid),     32'd1);
        check("add dest",       32'(bus.out_dest),      32'd1);
        check("add src1",       32'(bus.out_src1),      32'd2);
        check("add src2",       32'(bus.out_src2),      32'd3);
        check("add enables",    {29'd0, bus.out_rd1_en, bus.out_rd2_en, bus.out_wr_en}, 32'h7);
        check("add special",    32'(bus.out_special),   32'd1);
        check("add set_flags",  32'(bus.out_set_flags), 32'd0);
        check("add class",      32'(bus.out_class),     32'd1);
        check("add pc",         32'(bus.out_pc),        32'h0010);
        check("add pend1",      32'(dut.pending[1]),    32'd1);
        bus.wb_valid = 1'b1; bus.wb_addr = 3'd1;
        tick();
        bus.wb_valid = 1'b0;
        check("wb1 pend1",      32'(dut.pending[1]),    32'd0);
        check("idle out_valid", 32'(bus.out_valid),     32'd0);

        // MOV r1,#0x8001 then ADD r2,r1,r1 (RAW on r1)
        bus.in_valid = 1'b1; bus.in_instr = 32'h0040_8001; bus.in_pc = 16'h0020;
        tick();
        bus.in_instr = 32'h6289_0000; bus.in_pc = 16'h0024;
        check("mov imm",        bus.out_imm,            32'h0000_8001);
        check("mov enables",    {29'd0, bus.out_rd1_en, bus.out_rd2_en, bus.out_wr_en}, 32'h1);
        check("mov pend1",      32'(dut.pending[1]),    32'd1);
        settle();
        check("raw stall a",    32'(bus.in_ready),      32'd0);
        tick();
        check("raw stall b",    32'(bus.in_ready),      32'd0);
        check("raw bubble",     32'(bus.out_valid),     32'd0);
        bus.wb_valid = 1'b1; bus.wb_addr = 3'd1;
        tick();
        bus.wb_valid = 1'b0;
        settle();
        check("raw release",    32'(bus.in_ready),      32'd1);
        check("raw pend1",      32'(dut.pending[1]),    32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("add2 out_valid", 32'(bus.out_valid),     32'd1);
        check("add2 fields",    {23'd0, bus.out_dest, bus.out_src1, bus.out_src2}, 32'o211);
        check("add2 pend2",     32'(dut.pending[2]),    32'd1);
        bus.wb_valid = 1'b1; bus.wb_addr = 3'd2;
        tick();
        bus.wb_valid = 1'b0;

        // LD r3,[r4,#-4] then OR r5,r6,#0xFFFC back to back
        bus.in_valid = 1'b1; bus.in_instr = 32'h82E0_FFFC; bus.in_pc = 16'h0030;
        tick();
        bus.in_instr = 32'h2770_FFFC; bus.in_pc = 16'h0034;
        check("ld imm",         bus.out_imm,            32'hFFFF_FFFC);
        check("ld mem_rd",      32'(bus.out_mem_rd),    32'd1);
        check("ld fields",      {23'd0, bus.out_dest, bus.out_src1, bus.out_src2}, 32'o340);
        check("ld special",     32'(bus.out_special),   32'd0);
        tick();
        check("or imm",         bus.out_imm,            32'h0000_FFFC);
        check("or enables",     {29'd0, bus.out_rd1_en, bus.out_rd2_en, bus.out_wr_en}, 32'h5);
        check("or alu_oc",      32'(bus.out_alu_oc),    32'd3);
        check("or fields",      {23'd0, bus.out_dest, bus.out_src1, bus.out_src2}, 32'o560);

        // Downstream back-pressure with a store waiting at the input
        bus.out_ready = 1'b0;
        bus.in_instr = 32'h81C0_0008; bus.in_pc = 16'h0038;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("bp in_ready",  32'(bus.in_ready),  32'd0);
            tick();
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
            check("bp hold dest", 32'(bus.out_dest),  32'd5);
            check("bp hold pc",   32'(bus.out_pc),    32'h0034);
        end
        bus.out_ready = 1'b1;
        settle();
        check("bp release",     32'(bus.in_ready),      32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("st out_valid",   32'(bus.out_valid),     32'd1);
        check("st mem_wr",      32'(bus.out_mem_wr),    32'd1);
        check("st enables",     {29'd0, bus.out_rd1_en, bus.out_rd2_en, bus.out_wr_en}, 32'h6);
        check("st fields",      {23'd0, bus.out_dest, bus.out_src1, bus.out_src2}, 32'o007);
        check("st imm",         bus.out_imm,            32'h0000_0008);
        bus.wb_valid = 1'b1; bus.wb_addr = 3'd3;
        tick();
        bus.wb_addr = 3'd5;
        tick();
        bus.wb_addr = 3'd0;
        tick();
        bus.wb_valid = 1'b0;
        check("wb pend3",       32'(dut.pending[3]),    32'd0);
        check("wb pend5",       32'(dut.pending[5]),    32'd0);
        check("wb at zero",     32'(dut.pending[0]),    32'd0);

        // MOV r4 then flush with a NOP offered
        bus.in_valid = 1'b1; bus.in_instr = 32'h0100_0000; bus.in_pc = 16'h0040;
        tick();
        check("mov4 out_valid", 32'(bus.out_valid),     32'd1);
        bus.flush = 1'b1; bus.in_instr = 32'hC800_0000; bus.in_pc = 16'h0044;
        settle();
        check("flush in_ready", 32'(bus.in_ready),      32'd0);
        tick();
        bus.flush = 1'b0; bus.in_instr = 32'h0100_0000; bus.in_pc = 16'h0048;
        check("flush out_valid",32'(bus.out_valid),     32'd0);
        check("flush pend4",    32'(dut.pending[4]),    32'd1);
        settle();
        check("waw stall",      32'(bus.in_ready),      32'd0);
        bus.in_valid = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_addr = 3'd4;
        tick();
        bus.wb_valid = 1'b0;
        check("wb4 pend4",      32'(dut.pending[4]),    32'd0);

        // B.cond with negative offset, then an unused class-11 encoding
        bus.in_valid = 1'b1; bus.in_instr = 32'hC340_8000; bus.in_pc = 16'h0050;
        tick();
        bus.in_instr = 32'hC600_0000; bus.in_pc = 16'h0054;
        check("bcc branch",     32'(bus.out_branch),    32'd1);
        check("bcc cond",       32'(bus.out_cond),      32'hA);
        check("bcc imm",        bus.out_imm,            32'hFFFF_8000);
        check("bcc enables",    {29'd0, bus.out_rd1_en, bus.out_rd2_en, bus.out_wr_en}, 32'h0);
        tick();
        check("ill illegal",    32'(bus.out_illegal),   32'd1);
        check("ill branch",     32'(bus.out_branch),    32'd0);

        // MOV r2 left in flight, then HALT, then reset mid-operation
        bus.in_instr = 32'h0080_0000; bus.in_pc = 16'h0058;
        tick();
        bus.in_instr = 32'hD000_0000; bus.in_pc = 16'h005C;
        tick();
        bus.in_instr = 32'hC800_0000; bus.in_pc = 16'h0060;
        check("halt out_halt",  32'(bus.out_halt),      32'd1);
        check("halt out_valid", 32'(bus.out_valid),     32'd1);
        check("halt halted",    32'(bus.halted),        32'd1);
        settle();
        check("halt in_ready",  32'(bus.in_ready),      32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("halted valid", 32'(bus.out_valid), 32'd0);
            check("halted ready", 32'(bus.in_ready),  32'd0);
            check("halted flag",  32'(bus.halted),    32'd1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.in_valid = 1'b0;
        settle();
        check("rst halted",     32'(bus.halted),        32'd0);
        check("rst out_pc",     32'(bus.out_pc),        32'd0);
        check("rst out_halt",   32'(bus.out_halt),      32'd0);
        check("rst pend2",      32'(dut.pending[2]),    32'd0);
        check("rst in_ready",   32'(bus.in_ready),      32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
